// File: rtl/bf16_pkg.sv
// bf16_pkg: shared BFloat16 definitions for the reduction datapath.
//   bf16_t        packed {sign, exponent, mantissa}
//   BF16_POS_ZERO +0.0 constant used to clear the accumulator
//   acc_state_e   reduction controller states
package bf16_pkg;

  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;

  typedef struct packed {
    logic                  s;
    logic [BF16_EXP_W-1:0] e;
    logic [BF16_MAN_W-1:0] m;
  } bf16_t;

  localparam bf16_t BF16_POS_ZERO = '{s: 1'b0, e: '0, m: '0};

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } acc_state_e;

endpackage

// File: rtl/bf16_add.sv
// bf16_add: combinational BFloat16 adder, round-to-nearest-even.
//   a_s/a_e/a_m  operand A (sign, exponent, mantissa)
//   b_s/b_e/b_m  operand B
//   y_s/y_e/y_m  rounded sum
// Exponent 0 is treated as zero (no subnormals); results below the
// normal range flush to a signed zero, results above it become infinity.
// An exact cancellation gives +0; two zeros of the same sign keep that sign.
module bf16_add
  import bf16_pkg::*;
(
  input  logic                  a_s,
  input  logic [BF16_EXP_W-1:0] a_e,
  input  logic [BF16_MAN_W-1:0] a_m,
  input  logic                  b_s,
  input  logic [BF16_EXP_W-1:0] b_e,
  input  logic [BF16_MAN_W-1:0] b_m,
  output logic                  y_s,
  output logic [BF16_EXP_W-1:0] y_e,
  output logic [BF16_MAN_W-1:0] y_m
);

  // Significands carry 16 extra fraction bits: hidden bit at [23], mantissa
  // [22:16], and room for guard plus sticky after alignment; [24] is carry.
  logic                     swap;
  logic                     l_s, s_s;
  logic [BF16_EXP_W-1:0]    l_e, s_e, d;
  logic [BF16_MAN_W-1:0]    l_m, s_m;
  logic [7:0]               l_mh, s_mh;
  logic [24:0]              l_ext, s_ext, s_sh, sum;
  logic                     sticky, sub, rnd, carry;
  logic [4:0]               lead;
  logic [23:0]              norm;
  logic [7:0]               frac_r;
  logic signed [10:0]       ex;

  always_comb begin
    // Order operands by magnitude so the subtraction never goes negative.
    swap  = {b_e, b_m} > {a_e, a_m};
    l_s   = swap ? b_s : a_s;
    l_e   = swap ? b_e : a_e;
    l_m   = swap ? b_m : a_m;
    s_s   = swap ? a_s : b_s;
    s_e   = swap ? a_e : b_e;
    s_m   = swap ? a_m : b_m;
    l_mh  = (l_e == 8'd0) ? 8'd0 : {1'b1, l_m};
    s_mh  = (s_e == 8'd0) ? 8'd0 : {1'b1, s_m};
    d     = l_e - s_e;
    l_ext = {1'b0, l_mh, 16'h0000};
    s_ext = {1'b0, s_mh, 16'h0000};

    // Bits shifted out are folded into the LSB so rounding still sees them.
    if (d >= 8'd25) begin
      s_sh   = '0;
      sticky = |s_mh;
    end else begin
      s_sh   = s_ext >> d;
      sticky = |(s_ext & ((25'd1 << d) - 25'd1));
    end
    s_sh[0] = s_sh[0] | sticky;

    sub = l_s ^ s_s;
    sum = sub ? (l_ext - s_sh) : (l_ext + s_sh);

    lead = 5'd0;
    for (int i = 0; i < 25; i++) begin
      if (sum[i]) lead = 5'(i);
    end

    // Leading one lands just above norm[23]; it is implied and dropped.
    norm   = sum[23:0] << (5'd24 - lead);
    rnd    = norm[16] & ((|norm[15:0]) | norm[17]);
    frac_r = {1'b0, norm[23:17]} + 8'(rnd);
    carry  = frac_r[7];
    ex     = $signed({3'b000, l_e}) + $signed({6'b000000, lead})
             - 11'sd23 + $signed({10'b0, carry});

    y_s = l_s;
    y_e = '0;
    y_m = '0;
    if (sum == 25'd0) begin
      y_s = sub ? 1'b0 : l_s;
    end else if (ex <= 11'sd0) begin
      y_e = '0;
    end else if (ex >= 11'sd255) begin
      y_e = 8'hff;
    end else begin
      y_e = ex[7:0];
      y_m = frac_r[6:0];
    end
  end

endmodule

// File: rtl/bf16_acc.sv
// bf16_acc: streaming BFloat16 reduction around bf16_add.
//   clk, nreset                 clock, synchronous active-low reset
//   valid_i/ready_o, last_i     term handshake; last_i closes early
//   s_i/e_i/m_i                 input term
//   valid_o/ready_i             result handshake
//   s_o/e_o/m_o                 registered sum
//   cnt_o                       terms folded into the current/presented sum
module bf16_acc
  import bf16_pkg::*;
#(
  parameter  int LEN   = 8,
  localparam int CNT_W = $clog2(LEN + 1)
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  last_i,
  input  logic                  s_i,
  input  logic [BF16_EXP_W-1:0] e_i,
  input  logic [BF16_MAN_W-1:0] m_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  s_o,
  output logic [BF16_EXP_W-1:0] e_o,
  output logic [BF16_MAN_W-1:0] m_o,
  output logic [CNT_W-1:0]      cnt_o
);

  acc_state_e            state;
  bf16_t                 acc;
  logic                  sum_s;
  logic [BF16_EXP_W-1:0] sum_e;
  logic [BF16_MAN_W-1:0] sum_m;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  close;

  bf16_add u_add (
    .a_s (acc.s),
    .a_e (acc.e),
    .a_m (acc.m),
    .b_s (s_i),
    .b_e (e_i),
    .b_m (m_i),
    .y_s (sum_s),
    .y_e (sum_e),
    .y_m (sum_m)
  );

  assign cnt_nxt = cnt_o + CNT_W'(1);
  // The LEN-th term closes the reduction whether or not last_i is also set.
  assign close   = (cnt_nxt == CNT_W'(LEN)) || last_i;

  // ready_o/valid_o are registers so neither depends on ready_i or valid_i.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state   <= ACC;
      acc     <= BF16_POS_ZERO;
      cnt_o   <= '0;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      s_o     <= 1'b0;
      e_o     <= '0;
      m_o     <= '0;
    end else begin
      case (state)
        ACC: begin
          if (valid_i) begin
            acc   <= '{s: sum_s, e: sum_e, m: sum_m};
            cnt_o <= cnt_nxt;
            if (close) begin
              state   <= DONE;
              ready_o <= 1'b0;
              valid_o <= 1'b1;
              s_o     <= sum_s;
              e_o     <= sum_e;
              m_o     <= sum_m;
            end
          end
        end
        DONE: begin
          // Result data registers keep their value after the handshake.
          if (ready_i) begin
            state   <= ACC;
            acc     <= BF16_POS_ZERO;
            cnt_o   <= '0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
          end
        end
        default: begin
          state   <= ACC;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_acc.sv
// tb_bf16_acc: scoreboard bench for bf16_acc. Stimulus pushes expected
// results; a monitor pops and compares at each output handshake.
module tb_bf16_acc;

  localparam int LEN = 8;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       valid_i = 1'b0;
  logic       last_i = 1'b0;
  logic       s_i = 1'b0;
  logic [7:0] e_i = 8'h00;
  logic [6:0] m_i = 7'h00;
  logic       ready_i = 1'b0;
  logic       ready_o, valid_o, s_o;
  logic [7:0] e_o;
  logic [6:0] m_o;
  logic [3:0] cnt_o;

  bf16_acc #(.LEN(LEN)) dut (
    .clk     (clk),
    .nreset  (nreset),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .last_i  (last_i),
    .s_i     (s_i),
    .e_i     (e_i),
    .m_i     (m_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .s_o     (s_o),
    .e_o     (e_o),
    .m_o     (m_o),
    .cnt_o   (cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] v;
    int          cnt;
  } exp_t;

  exp_t        expq[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          vo_cnt = 0;
  logic [15:0] macc = 16'h0000;
  int          mcnt = 0;
  bit          auto_exp = 1'b0;
  bit          rand_rdy = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Reference arithmetic: exact real sum, then round-to-nearest-even to bf16.
  function automatic real p2(input int k);
    real r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic real b2r(input logic [15:0] b);
    real r;
    if (b[14:7] == 8'd0) return 0.0;
    r = (1.0 + real'(int'(b[6:0])) / 128.0) * p2(int'(b[14:7]) - 127);
    return b[15] ? -r : r;
  endfunction

  function automatic logic [15:0] r2b(input real x);
    real a, sc, fr;
    int  e, fi;
    bit  s;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    a = s ? -x : x;
    e = 0;
    while (a >= p2(e + 1)) e++;
    while (a < p2(e)) e--;
    sc = a / p2(e) * 128.0;
    fi = int'($floor(sc));
    fr = sc - real'(fi);
    if (fr > 0.5 || (fr == 0.5 && (fi % 2) == 1)) fi++;
    if (fi == 256) begin
      fi = 128;
      e++;
    end
    return {s, 8'(e + 127), 7'(fi - 128)};
  endfunction

  function automatic exp_t mk(input logic [15:0] v, input int c);
    exp_t x;
    x.v = v;
    x.cnt = c;
    return x;
  endfunction

  // Monitor: sample 1 time unit after the falling edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #1;
      if (nreset) begin
        if (valid_o) vo_cnt++;
        chk("ready_vs_valid", ready_o, !valid_o);
        if (valid_o && ready_i) begin
          if (expq.size() == 0) begin
            chk("unexpected_result", valid_o, 0);
          end else begin
            x = expq.pop_front();
            chk("result", {s_o, e_o, m_o}, x.v);
            chk("result_cnt", cnt_o, x.cnt);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (rand_rdy) begin
        #2;
        ready_i = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input bit s, input logic [7:0] e, input logic [6:0] m, input bit last);
    int t = 0;
    while (!ready_o && t < 100) begin
      valid_i = 1'b0;
      @(negedge clk);
      t++;
    end
    if (!ready_o) begin
      chk("ready_timeout", ready_o, 1);
      return;
    end
    valid_i = 1'b1;
    s_i = s;
    e_i = e;
    m_i = m;
    last_i = last;
    macc = r2b(b2r(macc) + b2r({s, e, m}));
    mcnt++;
    if (mcnt == LEN || last) begin
      if (auto_exp) expq.push_back(mk(macc, mcnt));
      macc = 16'h0000;
      mcnt = 0;
    end
    @(negedge clk);
    valid_i = 1'b0;
    last_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      valid_i = 1'b0;
      last_i = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    last_i = 1'b0;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    macc = 16'h0000;
    mcnt = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (expq.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", expq.size(), 0);
  endtask

  initial begin
    time t0;
    repeat (3) @(negedge clk);
    chk("reset_valid", valid_o, 0);
    chk("reset_ready", ready_o, 1);
    chk("reset_cnt", cnt_o, 0);
    chk("reset_data", {s_o, e_o, m_o}, 16'h0000);
    nreset = 1'b1;
    ready_i = 1'b1;

    // Eight 1.0 -> 8.0, visible right after the 8th accept.
    expq.push_back(mk(16'h4100, 8));
    repeat (8) send(1'b0, 8'h7f, 7'h00, 1'b0);
    chk("latency_valid", valid_o, 1);
    idle(1);

    // Early close with last_i: 3.0.
    expq.push_back(mk(16'h4040, 3));
    send(1'b0, 8'h7f, 7'h00, 1'b0);
    send(1'b0, 8'h7f, 7'h00, 1'b0);
    send(1'b0, 8'h7f, 7'h00, 1'b1);
    chk("early_ready_low", ready_o, 0);
    idle(1);

    // Backpressure: result held, 2.0 terms not consumed.
    ready_i = 1'b0;
    expq.push_back(mk(16'h4040, 3));
    send(1'b0, 8'h7f, 7'h00, 1'b0);
    send(1'b0, 8'h7f, 7'h00, 1'b0);
    send(1'b0, 8'h7f, 7'h00, 1'b1);
    repeat (5) begin
      valid_i = 1'b1;
      s_i = 1'b0;
      e_i = 8'h80;
      m_i = 7'h00;
      @(negedge clk);
      chk("bp_valid", valid_o, 1);
      chk("bp_ready", ready_o, 0);
      chk("bp_data", {s_o, e_o, m_o}, 16'h4040);
      chk("bp_cnt", cnt_o, 3);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    expq.push_back(mk(16'h4100, 8));
    repeat (8) send(1'b0, 8'h7f, 7'h00, 1'b0);
    idle(1);

    // Cancellation with gaps: +0.
    expq.push_back(mk(16'h0000, 8));
    for (int i = 0; i < 8; i++) begin
      send(1'(i % 2), 8'h7f, 7'h00, 1'b0);
      if (i != 7) idle(1);
    end
    idle(1);

    // -0 alone -> +0.
    expq.push_back(mk(16'h0000, 1));
    send(1'b1, 8'h00, 7'h00, 1'b1);
    idle(1);

    // Reset mid-reduction discards the partial sum.
    repeat (3) send(1'b0, 8'h7f, 7'h00, 1'b0);
    chk("mid_cnt_before", cnt_o, 3);
    do_reset();
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_cnt", cnt_o, 0);
    expq.push_back(mk(16'h4100, 8));
    repeat (8) send(1'b0, 8'h7f, 7'h00, 1'b0);
    idle(1);

    // Reset in DONE drops the pending result.
    ready_i = 1'b0;
    send(1'b0, 8'h7f, 7'h00, 1'b0);
    send(1'b0, 8'h80, 7'h00, 1'b1);
    chk("done_pending_valid", valid_o, 1);
    do_reset();
    chk("done_rst_valid", valid_o, 0);
    chk("done_rst_ready", ready_o, 1);
    ready_i = 1'b1;
    drain();

    // Back-to-back: 17 cycles for two 8-term reductions, two valid cycles.
    expq.push_back(mk(16'h4100, 8));
    expq.push_back(mk(16'h4100, 8));
    vo_cnt = 0;
    t0 = $time;
    repeat (16) send(1'b0, 8'h7f, 7'h00, 1'b0);
    chk("b2b_cycles", ($time - t0) / 10, 17);
    idle(2);
    #2;
    chk("b2b_valid_cycles", vo_cnt, 2);
    drain();

    // Randomized terms, lengths, gaps and output backpressure.
    @(negedge clk);
    auto_exp = 1'b1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bit          rs, rl;
      logic [7:0]  re;
      logic [6:0]  rm;
      rs = 1'($urandom_range(0, 1));
      re = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(8'h70, 8'h8f));
      rm = 7'($urandom_range(0, 127));
      rl = ($urandom_range(0, 5) == 0);
      send(rs, re, rm, rl);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    if (mcnt != 0) send(1'b0, 8'h7f, 7'h00, 1'b1);
    rand_rdy = 1'b0;
    @(negedge clk);
    ready_i = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
